// File: rtl/rr_fifo_arbiter.sv
// Round-robin scheduler moving head words from four input FIFOs to four output FIFOs,
// plus the RESET/INIT/IDLE/ACTIVE control FSM and the FIFO threshold registers.
module rr_fifo_arbiter #(
    parameter int DATA_W  = 10,
    parameter int LIMIT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [LIMIT_W-1:0] limit_low,
    input  logic [LIMIT_W-1:0] limit_high,
    input  logic [DATA_W-1:0]  data0_in,
    input  logic [DATA_W-1:0]  data1_in,
    input  logic [DATA_W-1:0]  data2_in,
    input  logic [DATA_W-1:0]  data3_in,
    input  logic [3:0]         empty_in,
    input  logic [3:0]         almost_full_out,
    output logic [3:0]         pop_in,
    output logic [3:0]         push_out,
    output logic [DATA_W-1:0]  data_out,
    output logic [LIMIT_W-1:0] cfg_limit_low,
    output logic [LIMIT_W-1:0] cfg_limit_high,
    output logic [1:0]         state_out,
    output logic               idle_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0][DATA_W-1:0]  head;
    logic [3:0][1:0]         dest;
    logic [3:0]              req;
    logic [1:0]              ptr;
    logic [1:0]              gnt_idx;
    logic                    gnt_vld;
    logic                    pop;

    assign head = {data3_in, data2_in, data1_in, data0_in};

    // A head is eligible only when its own destination can take a word.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign dest[i] = head[i][DATA_W-1:DATA_W-2];
        assign req[i]  = !empty_in[i] && !almost_full_out[dest[i]];
    end

    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign pop    = (state == ST_ACTIVE) && !init && gnt_vld;
    assign pop_in = pop ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   state_nxt = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_nxt = init ? ST_INIT : ((empty_in != 4'hF) ? ST_ACTIVE : ST_IDLE);
            ST_ACTIVE: state_nxt = init ? ST_INIT : ((empty_in == 4'hF) ? ST_IDLE : ST_ACTIVE);
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RESET;
        else        state <= state_nxt;
    end

    assign state_out = state;

    // A push already registered still completes even if init arrives next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_out       <= '0;
            data_out       <= '0;
            ptr            <= '0;
            cfg_limit_low  <= '0;
            cfg_limit_high <= '0;
            idle_out       <= 1'b0;
        end else begin
            push_out <= pop ? (4'b0001 << dest[gnt_idx]) : 4'b0000;
            if (pop) data_out <= head[gnt_idx];
            if (state == ST_INIT) begin
                cfg_limit_low  <= limit_low;
                cfg_limit_high <= limit_high;
                ptr            <= '0;
            end else if (pop) begin
                ptr <= gnt_idx + 2'd1;
            end
            idle_out <= (state_nxt == ST_IDLE) && (empty_in == 4'hF) && !pop;
        end
    end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Directed bench for rr_fifo_arbiter: queue-level model of the input FIFOs and scheduler,
// checked every cycle, plus literal expectations for grant order and push data.
module tb_rr_fifo_arbiter;
    localparam int DW = 10;
    localparam int LW = 3;

    logic          clk, reset, init;
    logic [LW-1:0] limit_low, limit_high;
    logic [DW-1:0] din [4];
    logic [3:0]    empty_in, af;
    logic [3:0]    pop_in, push_out;
    logic [DW-1:0] data_out;
    logic [LW-1:0] cfg_lo, cfg_hi;
    logic [1:0]    state_out;
    logic          idle_out;

    rr_fifo_arbiter #(.DATA_W(DW), .LIMIT_W(LW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .limit_low(limit_low), .limit_high(limit_high),
        .data0_in(din[0]), .data1_in(din[1]), .data2_in(din[2]), .data3_in(din[3]),
        .empty_in(empty_in), .almost_full_out(af),
        .pop_in(pop_in), .push_out(push_out), .data_out(data_out),
        .cfg_limit_low(cfg_lo), .cfg_limit_high(cfg_hi),
        .state_out(state_out), .idle_out(idle_out)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Input FIFO contents as circular buffers with read/write counters.
    logic [DW-1:0] fmem [4][16];
    int            rd [4];
    int            wr [4];

    // Model state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE.
    int            m_state, m_ptr, m_gnt, m_ns;
    logic [3:0]    m_push;
    logic [DW-1:0] m_data;
    logic [LW-1:0] m_lo, m_hi;
    logic          m_idle;

    logic [3:0]    pop_log [$];
    logic [3:0]    push_log [$];
    logic [DW-1:0] dat_log [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) if (wr[i] != rd[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load(input int i, input logic [DW-1:0] w);
        fmem[i][wr[i] % 16] = w;
        wr[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            din[i]      = fmem[i][rd[i] % 16];
            empty_in[i] = (wr[i] == rd[i]);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_push = '0; m_data = '0;
        m_lo = '0; m_hi = '0; m_idle = 1'b0;
    endtask

    task automatic model_comb();
        logic [DW-1:0] w;
        bit emp;
        emp   = all_empty();
        m_gnt = -1;
        if (reset && m_state == 3 && !init) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                w = fmem[i][rd[i] % 16];
                if (m_gnt < 0 && wr[i] != rd[i] && !af[w[DW-1:DW-2]]) m_gnt = i;
            end
        end
        if (m_state == 0)      m_ns = 1;
        else if (init)         m_ns = 1;
        else if (m_state == 1) m_ns = 2;
        else                   m_ns = emp ? 2 : 3;
    endtask

    task automatic model_seq();
        logic [DW-1:0] w;
        if (!reset) begin
            model_reset();
        end else begin
            w      = (m_gnt >= 0) ? fmem[m_gnt][rd[m_gnt] % 16] : '0;
            m_push = (m_gnt >= 0) ? (4'b0001 << w[DW-1:DW-2]) : 4'b0000;
            if (m_gnt >= 0) m_data = w;
            if (m_state == 1) begin
                m_lo = limit_low; m_hi = limit_high; m_ptr = 0;
            end else if (m_gnt >= 0) begin
                m_ptr = (m_gnt + 1) % 4;
            end
            m_idle  = (m_ns == 2) && all_empty() && (m_gnt < 0);
            m_state = m_ns;
            if (m_gnt >= 0) rd[m_gnt]++;
        end
    endtask

    // One cycle: apply inputs after negedge, compare everything, advance on posedge.
    task automatic step();
        logic [3:0] e_pop;
        drive();
        #1;
        model_comb();
        e_pop = (m_gnt >= 0) ? (4'b0001 << m_gnt) : 4'b0000;
        chk("pop_in", pop_in, e_pop);
        chk("push_out", push_out, m_push);
        chk("data_out", data_out, m_data);
        chk("state_out", state_out, m_state);
        chk("idle_out", idle_out, m_idle);
        chk("cfg_lo", cfg_lo, m_lo);
        chk("cfg_hi", cfg_hi, m_hi);
        if (pop_in != 0) pop_log.push_back(pop_in);
        if (push_out != 0) begin
            push_log.push_back(push_out);
            dat_log.push_back(data_out);
        end
        @(posedge clk);
        model_seq();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        pop_log.delete(); push_log.delete(); dat_log.delete();
    endtask

    initial begin
        logic [3:0]    exp_p [4];
        logic [DW-1:0] exp_d [4];
        for (int i = 0; i < 4; i++) begin rd[i] = 0; wr[i] = 0; end
        reset = 1'b0; init = 1'b1; limit_low = 3'd3; limit_high = 3'd7; af = 4'b0000;
        model_reset();
        drive();
        #1;
        chk("rst_state", state_out, 2'b00);
        chk("rst_push", push_out, 4'b0000);
        chk("rst_pop", pop_in, 4'b0000);
        chk("rst_cfg", {cfg_hi, cfg_lo}, 6'd0);
        @(negedge clk);
        step();

        // 1: release at t=15, INIT captures thresholds, then IDLE
        reset = 1'b1;
        step(); step(); step();
        chk("t1_state_init", state_out, 2'b01);
        chk("t1_cfg_lo", cfg_lo, 3'd3);
        chk("t1_cfg_hi", cfg_hi, 3'd7);
        init = 1'b0;
        step();
        chk("t1_state_idle", state_out, 2'b10);
        chk("t1_strobes", {pop_in, push_out}, 8'h00);

        // 2: one word per FIFO, all to output 4
        clear_logs();
        load(0, 10'h0FF); load(1, 10'h0EE); load(2, 10'h0DD); load(3, 10'h0CC);
        for (int c = 0; c < 8; c++) step();
        exp_p = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_d = '{10'h0FF, 10'h0EE, 10'h0DD, 10'h0CC};
        chk("t2_npush", push_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_pop_order", pop_log[k], exp_p[k]);
            chk("t2_push", push_log[k], 4'b0001);
            chk("t2_data", dat_log[k], exp_d[k]);
        end
        chk("t2_idle", idle_out, 1'b1);
        chk("t2_state", state_out, 2'b10);

        // 3: destination one-hot follows data[9:8]
        clear_logs();
        load(0, 10'h0FF); load(1, 10'h1EE); load(2, 10'h2DD); load(3, 10'h3CC);
        for (int c = 0; c < 8; c++) step();
        for (int k = 0; k < 4; k++) chk("t3_push", push_log[k], exp_p[k]);

        // 4: FIFO1 blocked by almost-full output 5, then released
        clear_logs();
        af = 4'b0010;
        load(0, 10'h0A1); load(0, 10'h0A2); load(1, 10'h1EE); load(2, 10'h2B1); load(3, 10'h3C1);
        for (int c = 0; c < 7; c++) step();
        exp_p = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
        chk("t4_npop", pop_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("t4_pop_order", pop_log[k], exp_p[k]);
        chk("t4_state", state_out, 2'b11);
        clear_logs();
        af = 4'b0000;
        for (int c = 0; c < 4; c++) step();
        chk("t4_unblock", pop_log[0], 4'b0010);
        chk("t4_unblock_push", push_log[0], 4'b0010);

        // 5: init mid-ACTIVE; pointer must restart at 0
        clear_logs();
        load(0, 10'h0B1); load(0, 10'h0B2); load(0, 10'h0B3); load(1, 10'h0B9);
        step(); step();
        init = 1'b1;
        step();
        chk("t5_state", state_out, 2'b01);
        chk("t5_push_done", push_log.size(), 1);
        chk("t5_push_data", dat_log[0], 10'h0B1);
        init = 1'b0;
        clear_logs();
        for (int c = 0; c < 7; c++) step();
        chk("t5_first_after_init", pop_log[0], 4'b0001);
        chk("t5_order2", pop_log[1], 4'b0010);
        chk("t5_order3", pop_log[2], 4'b0001);

        // 6: async reset while a push is visible
        load(2, 10'h2DD);
        step(); step();
        chk("t6_push_pre", push_out, 4'b0100);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_push", push_out, 4'b0000);
        chk("t6_data", data_out, 10'h000);
        chk("t6_state", state_out, 2'b00);
        chk("t6_pop", pop_in, 4'b0000);
        model_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
